// File: rtl/mem_bus_arbiter.sv
// Byte-wide bus arbiter/decoder: round-robin among masters, debug override,
// locked bursts, IO-full stall and a registered one-cycle read-return path.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int DBG_MASTER     = 0
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            dbg_active,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_wr,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
  input  logic [NUM_MASTERS*8-1:0]        m_dout,
  output logic [NUM_MASTERS-1:0]          m_gnt,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  output logic [7:0]                      m_din,
  output logic                            ram_en,
  output logic                            ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0]       ram_a,
  output logic [7:0]                      ram_dout,
  input  logic [7:0]                      ram_din,
  output logic                            io_en,
  output logic                            io_wr,
  output logic [IO_SEL_WIDTH-1:0]         io_sel,
  output logic [7:0]                      io_dout,
  input  logic [7:0]                      io_din,
  input  logic                            io_full
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
  logic             rd_pending_q, rd_pending_d;
  logic [IDX_W-1:0] rd_master_q, rd_master_d;
  logic             rd_is_io_q, rd_is_io_d;

  logic [NUM_MASTERS-1:0] io_hit;
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] upper_mask;
  logic [NUM_MASTERS-1:0] hi_req;
  logic [NUM_MASTERS-1:0] rr_pick;
  logic [NUM_MASTERS-1:0] gnt_vec;
  logic                   lock_hit;
  logic                   granted;
  logic [IDX_W-1:0]       win_idx;
  logic [RAM_ADDR_WIDTH-1:0] win_a;
  logic [7:0]             win_d;
  logic                   win_wr;
  logic                   win_lock;
  logic                   win_io;
  logic                   unused_addr_bits;

  // Only the low address bits reach the slaves; the rest is don't-care.
  assign unused_addr_bits = ^m_a;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    assign io_hit[gi]     = (m_a[gi*ADDR_WIDTH + RAM_ADDR_WIDTH -: 2] == 2'b11);
    assign elig[gi]       = m_req[gi] & ~(io_hit[gi] & m_wr[gi] & io_full);
    assign upper_mask[gi] = (IDX_W'(gi) >= rr_ptr_q);
    assign m_rvalid[gi]   = rd_pending_q & ~rst_in & (rd_master_q == IDX_W'(gi));
  end

  // Round-robin: lowest eligible index at or above rr_ptr, else wrap to the lowest overall.
  assign hi_req   = elig & upper_mask;
  assign rr_pick  = (|hi_req) ? (hi_req & (~hi_req + ONE)) : (elig & (~elig + ONE));
  assign lock_hit = lock_valid_q & elig[lock_owner_q];

  always_comb begin
    gnt_vec = '0;
    if (rst_in) begin
      gnt_vec = '0;
    end else if (dbg_active) begin
      gnt_vec[DBG_MASTER] = elig[DBG_MASTER];
    end else if (lock_hit) begin
      gnt_vec[lock_owner_q] = 1'b1;
    end else begin
      gnt_vec = rr_pick;
    end
  end

  assign granted = |gnt_vec;
  assign m_gnt   = gnt_vec;

  always_comb begin
    win_idx  = '0;
    win_a    = '0;
    win_d    = '0;
    win_wr   = 1'b0;
    win_lock = 1'b0;
    win_io   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_vec[i]) begin
        win_idx  = IDX_W'(i);
        win_a    = m_a[i*ADDR_WIDTH +: RAM_ADDR_WIDTH];
        win_d    = m_dout[i*8 +: 8];
        win_wr   = m_wr[i];
        win_lock = m_lock[i];
        win_io   = io_hit[i];
      end
    end
  end

  // Slave side is all-zero when nobody wins because the winner fields default to 0.
  assign ram_en   = granted & ~win_io;
  assign io_en    = granted & win_io;
  assign ram_wr   = ram_en & win_wr;
  assign io_wr    = io_en & win_wr;
  assign ram_a    = win_a;
  assign io_sel   = win_a[IO_SEL_WIDTH-1:0];
  assign ram_dout = win_d;
  assign io_dout  = win_d;

  // Region select is the registered one, so a new grant cannot disturb this return.
  assign m_din = rd_is_io_q ? io_din : ram_din;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = 1'b0;
    lock_owner_d = lock_owner_q;
    rd_pending_d = 1'b0;
    rd_master_d  = rd_master_q;
    rd_is_io_d   = rd_is_io_q;
    if (granted) begin
      if (!win_lock) begin
        rr_ptr_d = (win_idx == IDX_W'(NUM_MASTERS-1)) ? '0 : win_idx + IDX_W'(1);
      end
      lock_valid_d = win_lock;
      lock_owner_d = win_idx;
      rd_pending_d = ~win_wr;
      rd_master_d  = win_idx;
      rd_is_io_d   = win_io;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      rd_pending_q <= 1'b0;
      rd_master_q  <= '0;
      rd_is_io_q   <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      rd_pending_q <= rd_pending_d;
      rd_master_q  <= rd_master_d;
      rd_is_io_q   <= rd_is_io_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic checked against a rule-level reference model.
module tb_mem_bus_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int RAW = 17;
  localparam int IOW = 3;
  localparam int DBG = 0;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic            rst_in, dbg_active, io_full;
  logic [N-1:0]    m_req, m_wr, m_lock;
  logic [N*AW-1:0] m_a;
  logic [N*8-1:0]  m_dout;
  logic [N-1:0]    m_gnt, m_rvalid;
  logic [7:0]      m_din;
  logic            ram_en, ram_wr, io_en, io_wr;
  logic [RAW-1:0]  ram_a;
  logic [7:0]      ram_dout, ram_din, io_dout, io_din;
  logic [IOW-1:0]  io_sel;

  mem_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW),
    .IO_SEL_WIDTH(IOW), .DBG_MASTER(DBG)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .dbg_active(dbg_active),
    .m_req(m_req), .m_wr(m_wr), .m_lock(m_lock), .m_a(m_a), .m_dout(m_dout),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_din(m_din),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
    .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel), .io_dout(io_dout), .io_din(io_din),
    .io_full(io_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic show(input string tag);
    $display("[%0t] %s rst=%b dbg=%b req=%b gnt=%b rvalid=%b din=%h ram_en=%b io_en=%b",
             $time, tag, rst_in, dbg_active, m_req, m_gnt, m_rvalid, m_din, ram_en, io_en);
  endtask

  task automatic set_m(input int i, input bit req, input bit wr, input bit lock,
                       input logic [AW-1:0] a, input logic [7:0] d);
    m_req[i]          = req;
    m_wr[i]           = wr;
    m_lock[i]         = lock;
    m_a[i*AW +: AW]   = a;
    m_dout[i*8 +: 8]  = d;
  endtask

  task automatic drive_idle();
    m_req = '0; m_wr = '0; m_lock = '0; m_a = '0; m_dout = '0;
    dbg_active = 1'b0; io_full = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    drive_idle();
    #4;
    chk("rst_gnt", m_gnt, 0);
    chk("rst_rvalid", m_rvalid, 0);
    next_cycle();
    rst_in = 1'b0;
  endtask

  // ---------------- reference model (rule level) ----------------
  int rr_m, lock_m, pend_m;
  bit pend_io_m;

  function automatic bit io_region(input logic [AW-1:0] a);
    return a[RAW -: 2] == 2'b11;
  endfunction

  function automatic int pick_winner();
    bit el[N];
    for (int i = 0; i < N; i++)
      el[i] = m_req[i] && !(io_region(m_a[i*AW +: AW]) && m_wr[i] && io_full);
    if (rst_in) return -1;
    if (dbg_active) return el[DBG] ? DBG : -1;
    if (lock_m >= 0 && el[lock_m]) return lock_m;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr_m + k) % N;
      if (el[j]) return j;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] wr;
    logic [N-1:0] gnt;
    logic [N-1:0] rvalid;
    logic         ram_en;
    logic         ram_wr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int w;
    logic [AW-1:0] wa;
    logic [AW-1:0] a;
    bit wio;

    tbl[0] = '{3'b111, 3'b000, 3'b001, 3'b000, 1'b1, 1'b0};
    tbl[1] = '{3'b111, 3'b000, 3'b010, 3'b001, 1'b1, 1'b0};
    tbl[2] = '{3'b111, 3'b000, 3'b100, 3'b010, 1'b1, 1'b0};
    tbl[3] = '{3'b111, 3'b000, 3'b001, 3'b100, 1'b1, 1'b0};
    tbl[4] = '{3'b111, 3'b000, 3'b010, 3'b001, 1'b1, 1'b0};
    tbl[5] = '{3'b111, 3'b000, 3'b100, 3'b010, 1'b1, 1'b0};
    tbl[6] = '{3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0};
    tbl[7] = '{3'b010, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1};
    tbl[8] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};

    ram_din = 8'h00; io_din = 8'h00;
    do_reset();

    // Vector table: round-robin reads, idle, a RAM write
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < N; i++)
        set_m(i, tbl[v].req[i], tbl[v].wr[i], 1'b0, 32'h100 + i, 8'(8'h20 + i));
      ram_din = 8'($urandom);
      io_din  = ram_din ^ 8'hFF;
      #4;
      chk("tbl_gnt", m_gnt, tbl[v].gnt);
      chk("tbl_rvalid", m_rvalid, tbl[v].rvalid);
      chk("tbl_ram_en", ram_en, tbl[v].ram_en);
      chk("tbl_ram_wr", ram_wr, tbl[v].ram_wr);
      chk("tbl_io_en", io_en, 0);
      if (tbl[v].rvalid != 0) chk("tbl_din", m_din, ram_din);
      show("tbl");
      next_cycle();
    end

    // IO write stalled by io_full for three cycles
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h0003_0000, 8'h41);
      io_full = (c < 3);
      #4;
      if (c < 3) begin
        chk("iofull_gnt", m_gnt, 0);
        chk("iofull_io_en", io_en, 0);
      end else begin
        chk("iofull_gnt4", m_gnt, 3'b010);
        chk("iofull_io_en4", io_en, 1);
        chk("iofull_io_wr4", io_wr, 1);
        chk("iofull_io_sel4", io_sel, 0);
        chk("iofull_io_dout4", io_dout, 8'h41);
        chk("iofull_ram_en4", ram_en, 0);
      end
      show("iofull");
      next_cycle();
    end
    drive_idle();
    #4;
    chk("iofull_no_rvalid", m_rvalid, 0);
    next_cycle();

    // IO read then RAM read back-to-back
    do_reset();
    set_m(2, 1'b1, 1'b0, 1'b0, 32'h0003_0004, 8'h00);
    ram_din = 8'h11; io_din = 8'hA5;
    #4;
    chk("ioram_gnt_T", m_gnt, 3'b100);
    chk("ioram_io_en_T", io_en, 1);
    chk("ioram_io_sel_T", io_sel, 4);
    chk("ioram_ram_en_T", ram_en, 0);
    show("ioram");
    next_cycle();
    drive_idle();
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 8'h00);
    ram_din = 8'h3C; io_din = 8'h5A;
    #4;
    chk("ioram_gnt_T1", m_gnt, 3'b010);
    chk("ioram_ram_a_T1", ram_a, 17'h10);
    chk("ioram_io_en_T1", io_en, 0);
    chk("ioram_rvalid_T1", m_rvalid, 3'b100);
    chk("ioram_din_T1", m_din, 8'h5A);
    show("ioram");
    next_cycle();
    drive_idle();
    ram_din = 8'hC3; io_din = 8'h77;
    #4;
    chk("ioram_rvalid_T2", m_rvalid, 3'b010);
    chk("ioram_din_T2", m_din, 8'hC3);
    chk("ioram_io_en_T2", io_en, 0);
    show("ioram");
    next_cycle();

    // Four-byte locked burst from M1 against a competing M2
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_m(1, c < 4, 1'b0, c < 3, 32'h0000_0200 + c, 8'h00);
      set_m(2, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 8'h00);
      #4;
      chk("lock_gnt", m_gnt, (c < 4) ? 3'b010 : 3'b100);
      show("lock");
      next_cycle();
    end

    // Debug override during an M1 lock
    do_reset();
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] exp_g;
      set_m(0, (c == 1) || (c == 2) || (c == 3), 1'b0, 1'b0, 32'h0000_0040, 8'h00);
      set_m(1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 8'h00);
      dbg_active = (c == 2) || (c == 4);
      case (c)
        0, 1, 3: exp_g = 3'b010;
        2:       exp_g = 3'b001;
        default: exp_g = 3'b000;
      endcase
      #4;
      chk("dbg_gnt", m_gnt, exp_g);
      if (c == 3) chk("dbg_rvalid", m_rvalid, 3'b001);
      show("dbg");
      next_cycle();
    end

    // Reset right after an M0 read grant
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 8'h00);
    #4;
    chk("rstmid_gnt", m_gnt, 3'b001);
    show("rstmid");
    next_cycle();
    rst_in = 1'b1;
    #4;
    chk("rstmid_rvalid_in_rst", m_rvalid, 0);
    chk("rstmid_gnt_in_rst", m_gnt, 0);
    chk("rstmid_ram_en_in_rst", ram_en, 0);
    show("rstmid");
    next_cycle();
    rst_in = 1'b0;
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 8'h00);
    #4;
    chk("rstmid_rvalid_after", m_rvalid, 0);
    chk("rstmid_gnt_after", m_gnt, 3'b001);
    show("rstmid");
    next_cycle();

    // Randomized traffic against the reference model
    do_reset();
    rr_m = 0; lock_m = -1; pend_m = -1; pend_io_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst_in = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) dbg_active = ~dbg_active;
      io_full = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[RAW -: 2] = 2'b11;
        set_m(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, a, 8'($urandom));
      end
      ram_din = 8'($urandom);
      io_din  = 8'($urandom);
      w = pick_winner();
      wa = (w >= 0) ? m_a[w*AW +: AW] : '0;
      wio = (w >= 0) && io_region(wa);
      #4;
      chk("rnd_gnt", m_gnt, (w >= 0) ? (64'd1 << w) : 64'd0);
      chk("rnd_ram_en", ram_en, (w >= 0) && !wio);
      chk("rnd_io_en", io_en, (w >= 0) && wio);
      chk("rnd_ram_wr", ram_wr, (w >= 0) && !wio && m_wr[w]);
      chk("rnd_io_wr", io_wr, (w >= 0) && wio && m_wr[w]);
      chk("rnd_ram_a", ram_a, wa[RAW-1:0]);
      chk("rnd_io_sel", io_sel, wa[IOW-1:0]);
      chk("rnd_ram_dout", ram_dout, (w >= 0) ? m_dout[w*8 +: 8] : 8'h00);
      chk("rnd_io_dout", io_dout, (w >= 0) ? m_dout[w*8 +: 8] : 8'h00);
      chk("rnd_rvalid", m_rvalid, (!rst_in && pend_m >= 0) ? (64'd1 << pend_m) : 64'd0);
      if (!rst_in && pend_m >= 0) chk("rnd_din", m_din, pend_io_m ? io_din : ram_din);
      show("rnd");
      if (rst_in) begin
        rr_m = 0; lock_m = -1; pend_m = -1; pend_io_m = 1'b0;
      end else if (w >= 0) begin
        if (!m_lock[w]) rr_m = (w + 1) % N;
        lock_m    = m_lock[w] ? w : -1;
        pend_m    = m_wr[w] ? -1 : w;
        pend_io_m = wio;
      end else begin
        lock_m = -1;
        pend_m = -1;
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Parametrised memory/IO bus arbiter and decoder between NUM_MASTERS byte-wide bus masters (CPU fetch, CPU data, HCI debug, ...) and the shared RAM and HCI IO slaves. Successor to the single-master, fixed two-way mux in the top level.
- Adds round-robin arbitration, absolute debug priority, locked multi-byte bursts and IO-full back-pressure.
- Adds a registered per-master read-return path.
- Sits in riscv_top between the masters and ram/hci.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8)
ADDR_WIDTH, 32, master address width
RAM_ADDR_WIDTH, 17, RAM address width; IO region decoded from bits [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11
IO_SEL_WIDTH, 3, width of io_sel (low address bits)
DBG_MASTER, 0, index of the debug master with absolute priority while dbg_active

Ports:
clk_in  input  1  system clock; all state on rising edge
rst_in  input  1  synchronous, active-high reset
dbg_active  input  1  debug break; only DBG_MASTER may be granted
m_req  input  NUM_MASTERS  per-master request, held until granted
m_wr  input  NUM_MASTERS  per-master 1=write, 0=read
m_lock  input  NUM_MASTERS  keep grant for the next byte (burst)
m_a  input  NUM_MASTERS*ADDR_WIDTH  flattened addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_dout  input  NUM_MASTERS*8  flattened write data
m_gnt  output  NUM_MASTERS  one-hot grant, combinational, same cycle
m_rvalid  output  NUM_MASTERS  one-hot read-data valid, one cycle after a read grant
m_din  output  8  read data broadcast to all masters, qualified by m_rvalid
ram_en  output  1  RAM enable
ram_wr  output  1  RAM write (ram r_nw = ~ram_wr)
ram_a  output  RAM_ADDR_WIDTH  RAM address
ram_dout  output  8  RAM write data
ram_din  input  8  RAM read data (valid the cycle after ram_en)
io_en  output  1  HCI IO enable
io_wr  output  1  IO write
io_sel  output  IO_SEL_WIDTH  IO register select
io_dout  output  8  IO write data
io_din  input  8  IO read data (valid the cycle after io_en)
io_full  input  1  HCI transmit buffer full

Behaviour:
- Reset, applied at the next clock edge while rst_in=1:
  - rr_ptr=0, lock_owner invalid, rd_pending=0, rd_master=0, rd_is_io=0.
  - All registered outputs are 0: m_rvalid=0.
  - Combinational outputs (m_gnt, ram_en, io_en, ram_wr, io_wr) are forced to 0 while rst_in=1.
- Eligibility for master i: m_req[i]=1, and not (IO address and m_wr[i]=1 and io_full=1). An ineligible IO write stalls with no grant; other masters may win meanwhile.
- Winner selection, in priority order:
  - dbg_active=1: only DBG_MASTER may win, if eligible; all others get no grant.
  - Else, if lock_owner is valid and that master is eligible, it wins.
  - Else, round-robin: the first eligible master scanning from rr_ptr upward, wrapping modulo NUM_MASTERS.
- Grant cycle T:
  - m_gnt[winner]=1.
  - Slave signals are driven from the winner's address/data: IO region → io_en=1, else ram_en=1.
  - ram_a = m_a[RAM_ADDR_WIDTH-1:0]; io_sel = m_a[IO_SEL_WIDTH-1:0].
  - With no winner: ram_en=io_en=ram_wr=io_wr=0 and the slave address/data outputs hold 0.
- Edge ending T:
  - rr_ptr <= (winner+1) mod NUM_MASTERS, unless the grant was locked.
  - lock_owner <= winner if m_lock[winner]=1, else invalid.
  - rd_pending <= granted && !m_wr; rd_master <= winner; rd_is_io <= io region.
- Cycle T+1:
  - m_rvalid[rd_master] = rd_pending.
  - m_din = rd_is_io ? io_din : ram_din. This is the registered region select; a new grant in T+1 never corrupts the T+1 return.
- Throughput: one byte per cycle; back-to-back reads from different masters are legal.
- A lock is released by m_lock low, by m_req low, or by dbg_active rising. dbg_active overrides any lock immediately.
- Writes produce no m_rvalid.
- Reset mid-read: a pending rvalid is dropped; m_rvalid=0 in the cycle after reset.
- A master deasserting m_req without a grant is legal; no state changes.

Test Plan:
- Masters 0,1,2 request RAM reads continuously, dbg_active=0, from reset → grants 0,1,2,0,…; each m_rvalid follows its grant by exactly one cycle; m_din equals the ram_din of that cycle.
- M1 writes 0x41 to 0x30000, io_full=1 for 3 cycles, then 0 → no M1 grant and io_en=0 for 3 cycles; grant in cycle 4 with io_wr=1, io_sel=0, io_dout=0x41.
- M2 reads 0x30004 in cycle T, M1 reads RAM 0x00010 in T+1 → m_din in T+1=io_din and in T+2=ram_din; io_en was 1 only in T.
- M1 requests with m_lock=1 for 4 bytes while M2 requests → M1 granted 4 consecutive cycles, then M2.
- dbg_active=1 during an M1 lock → M0 (debug) granted next cycle and M1 stalls; dbg_active=0 → round-robin resumes at rr_ptr.
- rst_in=1 the cycle after an M0 read grant → m_rvalid stays 0 and the next grant goes to M0 from rr_ptr=0.
